// File: rtl/divide.sv
// Sequential sign-magnitude fixed-point divider, radix-2 restoring, one quotient bit per clock.
// Define ROUND_EN to compute a guard bit and round the quotient magnitude half up.
module divide #(
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH:0]   inputA,
  input  logic [WIDTH:0]   inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int FRAC = WIDTH / 2 + 1;
`ifdef ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NB = WIDTH + FRAC + RND;
  localparam int CW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB-1:0]      n_q, n_d;
  logic [NB-1:0]      q_q, q_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic               bz_q, bz_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               div0_q, div0_d;

  logic [WIDTH:0]         r_shift;
  logic [WIDTH-1:0]       diff;
  logic                   ge;
  logic [WIDTH+FRAC-1:0]  qt;
  logic                   guard;
  logic [WIDTH:0]         mag_r;
  logic                   sat;
  logic [WIDTH-1:0]       res_mag;

  // The remainder stays below |B| < 2^WIDTH, so a WIDTH-bit difference is exact when ge.
  assign r_shift = {rem_q, n_q[NB-1]};
  assign ge      = r_shift >= {1'b0, b_q};
  assign diff    = r_shift[WIDTH-1:0] - b_q;

  assign qt = q_q[NB-1 -: WIDTH+FRAC];
`ifdef ROUND_EN
  assign guard = q_q[0];
`else
  assign guard = 1'b0;
`endif
  assign mag_r   = {1'b0, qt[WIDTH-1:0]} + {{WIDTH{1'b0}}, guard};
  assign sat     = bz_q | (|qt[WIDTH+FRAC-1:WIDTH]) | mag_r[WIDTH];
  assign res_mag = sat ? {WIDTH{1'b1}} : mag_r[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    q_d      = q_q;
    rem_d    = rem_q;
    b_d      = b_q;
    sign_d   = sign_q;
    bz_d     = bz_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    div0_d   = div0_q;
    case (state_q)
      S_IDLE: begin
        // done_q marks the pulse cycle, during which the block still counts as busy
        if (start && !done_q) begin
          b_d    = inputB[WIDTH-1:0];
          sign_d = inputA[WIDTH] ^ inputB[WIDTH];
          bz_d   = (inputB[WIDTH-1:0] == '0);
          n_d    = {inputA[WIDTH-1:0], {(NB-WIDTH){1'b0}}};
          q_d    = '0;
          rem_d  = '0;
          ovf_d  = 1'b0;
          div0_d = 1'b0;
          // A zero divisor takes one dummy pass through CALC so done lands two edges after start
          cnt_d   = (inputB[WIDTH-1:0] == '0) ? '0 : CW'(NB - 1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = ge ? diff : r_shift[WIDTH-1:0];
        q_d   = {q_q[NB-2:0], ge};
        n_d   = {n_q[NB-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_d   = 1'b1;
        result_d = {sign_q, res_mag};
        ovf_d    = sat;
        div0_d   = bz_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      bz_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      bz_q     <= bz_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      div0_q   <= div0_d;
    end
  end

  assign busy        = (state_q != S_IDLE) | done_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign div_by_zero = div0_q;

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: directed cases plus randomized operands against an arithmetic model.
module tb_divide;
  localparam int W    = 31;
  localparam int FRAC = 16;
`ifdef ROUND_EN
  localparam int LAT = 49;
`else
  localparam int LAT = 48;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [W:0]  inputA;
  logic [W:0]  inputB;
  logic        busy;
  logic        done;
  logic [W:0]  result;
  logic        overflow;
  logic        div_by_zero;

  int n_total = 0;
  int n_pass  = 0;

  divide #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inputA(inputA), .inputB(inputB),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Returns {div_by_zero, overflow, result} from plain integer division of the magnitudes.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [63:0] ma, mb, q;
    s  = a[31] ^ b[31];
    ma = {33'd0, a[30:0]};
    mb = {33'd0, b[30:0]};
    if (mb == 0) return {1'b1, 1'b1, s, 31'h7FFF_FFFF};
`ifdef ROUND_EN
    q = (ma << (FRAC + 1)) / mb;
    q = (q >> 1) + (q & 64'd1);
`else
    q = (ma << FRAC) / mb;
`endif
    if (q > 64'h7FFF_FFFF) return {1'b0, 1'b1, s, 31'h7FFF_FFFF};
    return {2'b00, s, q[30:0]};
  endfunction

  // Drives start for one cycle from the current negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    inputA = a;
    inputB = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic finish(input string tag, input logic [31:0] b, input int lat0, input bit coincide,
                        input logic [31:0] exp_res, input logic exp_ov, input logic exp_dz);
    int lat;
    int exp_lat;
    lat     = lat0;
    exp_lat = (b[30:0] == 0) ? 2 : LAT;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_overflow"}, overflow, exp_ov);
    chk({tag, "_div0"}, div_by_zero, exp_dz);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    if (coincide) begin
      inputA = 32'h0005_0000;
      inputB = 32'h0001_0000;
      start  = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle_after"}, busy, 1'b0);
    chk({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    logic [33:0] m;
    logic [31:0] a, b;
    int          dcount;

    rst_n  = 1'b0;
    start  = 1'b0;
    inputA = '0;
    inputB = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_div0", div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(32'h0003_0000, 32'h0002_0000);
    finish("t1_3div2", 32'h0002_0000, 0, 1'b0, 32'h0001_8000, 1'b0, 1'b0);
    launch(32'h8006_0000, 32'h0003_0000);
    finish("t2_neg6div3", 32'h0003_0000, 0, 1'b1, 32'h8002_0000, 1'b0, 1'b0);
    launch(32'h8006_0000, 32'h8003_0000);
    finish("t2_neg6divneg3", 32'h8003_0000, 0, 1'b0, 32'h0002_0000, 1'b0, 1'b0);
`ifdef ROUND_EN
    launch(32'h0002_0000, 32'h0003_0000);
    finish("t3_2div3", 32'h0003_0000, 0, 1'b0, 32'h0000_AAAB, 1'b0, 1'b0);
`else
    launch(32'h0002_0000, 32'h0003_0000);
    finish("t3_2div3", 32'h0003_0000, 0, 1'b0, 32'h0000_AAAA, 1'b0, 1'b0);
`endif
    launch(32'h0001_0000, 32'h0003_0000);
    finish("t3_1div3", 32'h0003_0000, 0, 1'b0, 32'h0000_5555, 1'b0, 1'b0);
    launch(32'h0005_0000, 32'h8000_0000);
    finish("t4_div_neg0", 32'h8000_0000, 0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    chk("hold_div0_flag", div_by_zero, 1'b1);
    launch(32'h7FFF_FFFF, 32'h0000_0001);
    chk("start_clears_ovf", overflow, 1'b0);
    chk("start_clears_div0", div_by_zero, 1'b0);
    chk("start_keeps_result", result, 32'hFFFF_FFFF);
    finish("t5_max_div_lsb", 32'h0000_0001, 0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    launch(32'h0000_0000, 32'h0001_0000);
    finish("t5_zero_dividend", 32'h0001_0000, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);

    launch(32'h0003_0000, 32'h0002_0000);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 32'h0);
    dcount = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("midrst_no_done", dcount, 0);

    launch(32'h0002_0000, 32'h0003_0000);
    repeat (10) @(negedge clk);
    inputA = 32'h0007_0000;
    inputB = 32'h0001_0000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    m = model(32'h0002_0000, 32'h0003_0000);
    finish("busy_start_ignored", 32'h0003_0000, 11, 1'b0, m[31:0], m[32], m[33]);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      a[30:0] = a[30:0] >> $urandom_range(0, 24);
      b = $urandom;
      b[30:0] = b[30:0] >> $urandom_range(0, 30);
      if (i == 5) b[30:0] = '0;
      m = model(a, b);
      launch(a, b);
      finish($sformatf("rand%0d", i), b, 0, 1'($urandom_range(0, 1)), m[31:0], m[32], m[33]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
